// File: rtl/edge_det_pkg.sv
// Shared constants and helpers for the edge-event detector and its bench.
package edge_det_pkg;

  localparam int DEFAULT_WIDTH         = 8;
  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_FILTER_CYCLES = 4;

  // Bits needed to hold values 0 .. value-1 (at least 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel: synchroniser, optional debounce filter (EDGE_EVENT_DETECTOR_FILTER_EN),
// edge pulse generation and sticky pending flag.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int   p_SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int   p_FILTER_CYCLES = DEFAULT_FILTER_CYCLES,
  parameter logic p_RESET_LEVEL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_input,
  input  logic i_rise_en,
  input  logic i_fall_en,
  input  logic i_clear,
  output logic o_level,
  output logic o_pulse,
  output logic o_pending
);

  if (p_SYNC_STAGES < 2) begin : g_bad_sync
    $error("edge_det_channel: p_SYNC_STAGES must be >= 2");
  end
  if (p_FILTER_CYCLES < 1) begin : g_bad_filter
    $error("edge_det_channel: p_FILTER_CYCLES must be >= 1");
  end

  logic [p_SYNC_STAGES-1:0] r_sync;
  logic                     w_sync_out;
  logic                     w_level;
  logic                     r_prev;
  logic                     r_pulse;
  logic                     r_pending;
  logic                     w_rise;
  logic                     w_fall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= {p_SYNC_STAGES{p_RESET_LEVEL}};
    else          r_sync <= {r_sync[p_SYNC_STAGES-2:0], i_input};
  end

  assign w_sync_out = r_sync[p_SYNC_STAGES-1];

`ifdef EDGE_EVENT_DETECTOR_FILTER_EN
  localparam int                 c_CNT_W    = clog2(p_FILTER_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(p_FILTER_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_level;

  // Level only moves after p_FILTER_CYCLES consecutive disagreeing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= p_RESET_LEVEL;
    end else if (w_sync_out == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_cnt   <= '0;
      r_level <= ~r_level;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_level;
`else
  assign w_level = w_sync_out;
`endif

  assign w_rise = w_level & ~r_prev;
  assign w_fall = ~w_level & r_prev;

  // A pulse landing in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev    <= p_RESET_LEVEL;
      r_pulse   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_prev  <= w_level;
      r_pulse <= (w_rise & i_rise_en) | (w_fall & i_fall_en);
      if (r_pulse)      r_pending <= 1'b1;
      else if (i_clear) r_pending <= 1'b0;
    end
  end

  assign o_level   = w_level;
  assign o_pulse   = r_pulse;
  assign o_pending = r_pending;

endmodule

// File: rtl/edge_event_detector.sv
// Multi-channel edge-event detector with maskable combined interrupt.
// Debounce filter is built when EDGE_EVENT_DETECTOR_FILTER_EN is defined.
module edge_event_detector
  import edge_det_pkg::*;
#(
  parameter int                 p_WIDTH         = DEFAULT_WIDTH,
  parameter int                 p_SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int                 p_FILTER_CYCLES = DEFAULT_FILTER_CYCLES,
  parameter logic [p_WIDTH-1:0] p_RESET_LEVEL   = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [p_WIDTH-1:0] iv_input,
  input  logic [p_WIDTH-1:0] iv_rise_en,
  input  logic [p_WIDTH-1:0] iv_fall_en,
  input  logic [p_WIDTH-1:0] iv_clear,
  input  logic [p_WIDTH-1:0] iv_irq_mask,
  output logic [p_WIDTH-1:0] ov_level,
  output logic [p_WIDTH-1:0] ov_pulse,
  output logic [p_WIDTH-1:0] ov_pending,
  output logic               o_irq
);

  if (p_WIDTH < 1) begin : g_bad_width
    $error("edge_event_detector: p_WIDTH must be >= 1");
  end

  for (genvar i = 0; i < p_WIDTH; i++) begin : g_ch
    edge_det_channel #(
      .p_SYNC_STAGES  (p_SYNC_STAGES),
      .p_FILTER_CYCLES(p_FILTER_CYCLES),
      .p_RESET_LEVEL  (p_RESET_LEVEL[i])
    ) u_channel (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_input  (iv_input[i]),
      .i_rise_en(iv_rise_en[i]),
      .i_fall_en(iv_fall_en[i]),
      .i_clear  (iv_clear[i]),
      .o_level  (ov_level[i]),
      .o_pulse  (ov_pulse[i]),
      .o_pending(ov_pending[i])
    );
  end

  assign o_irq = |(ov_pending & iv_irq_mask);

endmodule

// File: tb/tb_edge_event_detector.sv
// Scoreboard bench for edge_event_detector: stimulus queues expected pulses, a monitor checks them.
module tb_edge_event_detector;
  import edge_det_pkg::*;

  localparam int W = DEFAULT_WIDTH;
  localparam int S = DEFAULT_SYNC_STAGES;
  localparam int F = DEFAULT_FILTER_CYCLES;
`ifdef EDGE_EVENT_DETECTOR_FILTER_EN
  localparam int FILT = 1;
  localparam int LVL  = S + F;
`else
  localparam int FILT = 0;
  localparam int LVL  = S;
`endif
  localparam int LAT = LVL + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] vec;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_v, rise_v, fall_v, clr_v, mask_v;
  logic [W-1:0] level, pulse, pending;
  logic         irq;
  logic [W-1:0] level2, pulse2, pending2;
  logic         irq2;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   dut2_pulsed = 1'b0;
  exp_t exp_q[$];

  edge_event_detector #(
    .p_WIDTH(W), .p_SYNC_STAGES(S), .p_FILTER_CYCLES(F), .p_RESET_LEVEL(8'h00)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .iv_input(in_v), .iv_rise_en(rise_v),
    .iv_fall_en(fall_v), .iv_clear(clr_v), .iv_irq_mask(mask_v),
    .ov_level(level), .ov_pulse(pulse), .ov_pending(pending), .o_irq(irq)
  );

  // Idle level of FF with inputs held at FF: must never pulse.
  edge_event_detector #(
    .p_WIDTH(W), .p_SYNC_STAGES(S), .p_FILTER_CYCLES(F), .p_RESET_LEVEL(8'hFF)
  ) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .iv_input(8'hFF), .iv_rise_en(8'hFF),
    .iv_fall_en(8'hFF), .iv_clear(8'h00), .iv_irq_mask(8'hFF),
    .ov_level(level2), .ov_pulse(pulse2), .ov_pending(pending2), .o_irq(irq2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [W-1:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard when an expected pulse cycle arrives, flags anything else.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_pulse: got none expected %h at cycle %0d", exp_q[0].vec, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("pulse", 32'(pulse), 32'(exp_q[0].vec));
        void'(exp_q.pop_front());
      end else if (pulse != '0) begin
        check("unexpected_pulse", 32'(pulse), 32'h0);
      end
    end
    if (pulse2 != '0) dut2_pulsed = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;
    rst_n  = 1'b0;
    in_v   = 8'hFF;
    rise_v = 8'hFF;
    fall_v = 8'hFF;
    clr_v  = 8'h00;
    mask_v = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("reset_pulse", 32'(pulse), 32'h0);
    check("reset_pending", 32'(pending), 32'h0);
    check("reset_level", 32'(level), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);

    // 1: release reset with inputs already high -> one rise per channel.
    n = cyc;
    rst_n = 1'b1;
    push(n + LAT, 8'hFF);
    to_cyc(n + LVL - 1);
    check("level_before_accept", 32'(level), 32'h00);
    to_cyc(n + LVL);
    check("level_after_accept", 32'(level), 32'hFF);
    to_cyc(n + LAT + 1);
    check("pending_after_reset_rise", 32'(pending), 32'hFF);
    clr_v = 8'hFF;
    @(negedge clk);
    clr_v = 8'h00;
    check("pending_cleared_all", 32'(pending), 32'h00);

    // 2: all fall, then latency of a single rise on ch0.
    n = cyc;
    in_v = 8'h00;
    push(n + LAT, 8'hFF);
    to_cyc(n + LAT + 3);
    rise_v = 8'h01;
    fall_v = 8'h00;
    n = cyc;
    in_v = 8'h01;
    push(n + LAT, 8'h01);
    to_cyc(n + LVL - 1);
    check("ch0_level_pre", 32'(level[0]), 32'h0);
    to_cyc(n + LVL);
    check("ch0_level_post", 32'(level[0]), 32'h1);
    to_cyc(n + LAT + 3);

    // 3: glitch rejection on ch1.
    rise_v = 8'h02;
    fall_v = 8'h02;
    n = cyc;
    if (FILT == 0) begin
      push(n + LAT, 8'h02);
      push(n + 3 + LAT, 8'h02);
    end
    in_v = 8'h03;
    to_cyc(n + 3);
    in_v = 8'h01;
    to_cyc(n + LAT + 6);
    check("ch1_glitch_level", 32'(level[1]), 32'h0);
    n = cyc;
    push(n + LAT, 8'h02);
    push(n + 4 + LAT, 8'h02);
    in_v = 8'h03;
    to_cyc(n + 4);
    in_v = 8'h01;
    to_cyc(n + 4 + LAT + 3);
    check("ch1_level_after_pulse", 32'(level[1]), 32'h0);

    // 4: fall-only mode on ch2 with a square wave, then enable toggles with static input.
    rise_v = 8'h00;
    fall_v = 8'h04;
    n = cyc;
    for (int k = 0; k < 3; k++) push(n + 10 * k + 5 + LAT, 8'h04);
    for (int k = 0; k < 3; k++) begin
      to_cyc(n + 10 * k);
      in_v = 8'h05;
      to_cyc(n + 10 * k + 5);
      in_v = 8'h01;
    end
    to_cyc(n + 30 + LAT + 3);
    for (int k = 0; k < 8; k++) begin
      rise_v = (k % 2 == 0) ? 8'hFF : 8'h00;
      fall_v = (k % 3 == 0) ? 8'hFF : 8'h00;
      @(negedge clk);
    end
    rise_v = 8'h00;
    fall_v = 8'h00;
    repeat (LAT + 2) @(negedge clk);

    // 5: pending, irq masking and clear priority on ch3.
    clr_v = 8'hFF;
    @(negedge clk);
    clr_v = 8'h00;
    mask_v = 8'h08;
    rise_v = 8'h08;
    fall_v = 8'h08;
    n = cyc;
    in_v = 8'h09;
    push(n + LAT, 8'h08);
    to_cyc(n + LAT + 1);
    check("ch3_pending_set", 32'(pending[3]), 32'h1);
    check("irq_raised", 32'(irq), 32'h1);
    mask_v = 8'h00;
    #1 check("irq_masked", 32'(irq), 32'h0);
    mask_v = 8'h08;
    #1 check("irq_unmask_immediate", 32'(irq), 32'h1);
    m = cyc;
    in_v = 8'h01;
    push(m + LAT, 8'h08);
    to_cyc(m + LAT);
    clr_v = 8'h08;
    @(negedge clk);
    clr_v = 8'h00;
    check("set_wins_over_clear", 32'(pending[3]), 32'h1);
    clr_v = 8'h08;
    @(negedge clk);
    clr_v = 8'h00;
    check("lone_clear_pending", 32'(pending[3]), 32'h0);
    check("lone_clear_irq", 32'(irq), 32'h0);
    clr_v = 8'h08;
    @(negedge clk);
    clr_v = 8'h00;
    check("clear_noop", 32'(pending[3]), 32'h0);
    n = cyc;
    in_v = 8'h09;
    push(n + LAT, 8'h08);
    to_cyc(n + LAT + 1);
    check("pending_before_reset", 32'(pending), 32'h08);

    // 6: asynchronous reset in the middle of a filter run on ch4 (disabled channel).
    n = cyc;
    in_v = 8'h19;
    to_cyc(n + 4);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_pulse", 32'(pulse), 32'h0);
    check("midreset_pending", 32'(pending), 32'h0);
    check("midreset_irq", 32'(irq), 32'h0);
    check("midreset_level", 32'(level), 32'h0);
    in_v = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    n = cyc;
    to_cyc(n + LAT + 4);
    check("post_reset_level", 32'(level), 32'h0);
    check("post_reset_pending", 32'(pending), 32'h0);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("idle_ff_no_pulse", 32'(dut2_pulsed), 32'h0);
    check("idle_ff_level", 32'(level2), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
